// File: rtl/cordic_pol2cart_if.sv
// Streaming polar-in / cartesian-out bundle for cordic_pol2cart.
// The source drives r/theta/ctrl_in, and the CORDIC returns x/y/ctrl_out.
interface cordic_pol2cart_if #(
  parameter int ITERATIONS = 7,
  parameter int DATA_WIDTH = 16,
  parameter int CTRL_WIDTH = 1
);
  logic signed [DATA_WIDTH-1:0] r;
  logic        [ITERATIONS:0]   theta;
  logic        [CTRL_WIDTH-1:0] ctrl_in;
  logic signed [DATA_WIDTH+1:0] x;
  logic signed [DATA_WIDTH+1:0] y;
  logic        [CTRL_WIDTH-1:0] ctrl_out;

  modport master (output r, theta, ctrl_in, input x, y, ctrl_out);
  modport slave  (input r, theta, ctrl_in, output x, y, ctrl_out);
endinterface

// File: rtl/cordic_pol2cart.sv
// Pipelined rotation-mode CORDIC, polar (r, theta) to cartesian (x, y), fixed latency ITERATIONS+3.
// The arctangent table and 1/K constant are tabulated for the default ITERATIONS = 7 (16-bit angle scale).
module cordic_pol2cart #(
  parameter int ITERATIONS           = 7,
  parameter int DATA_WIDTH           = 16,
  parameter int CTRL_WIDTH           = 1,
  parameter int COMPENSATION_SCALING = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  cordic_pol2cart_if.slave io
);

  localparam int N    = ITERATIONS + 1;
  localparam int Q    = 1 << (N - 2);
  localparam int XW   = DATA_WIDTH + 2;
  localparam int ZW   = N + 9;
  localparam int LAT  = ITERATIONS + 3;
  localparam int PW   = XW + 17;
  localparam int KINV = 39797;
  localparam logic signed [PW-1:0] KINV_S = PW'(KINV);

  // atan(2^-i) in units of 2*pi / 2^(N+8), rounded to nearest
  function automatic logic signed [ZW-1:0] atan_lut(input int idx);
    case (idx)
      0:       atan_lut = ZW'(8192);
      1:       atan_lut = ZW'(4836);
      2:       atan_lut = ZW'(2555);
      3:       atan_lut = ZW'(1297);
      4:       atan_lut = ZW'(651);
      5:       atan_lut = ZW'(326);
      6:       atan_lut = ZW'(163);
      default: atan_lut = '0;
    endcase
  endfunction

  logic signed [DATA_WIDTH-1:0] r_d, r_q;
  logic        [N-1:0]          theta_d, theta_q;
  logic signed [XW-1:0]         xs_d [0:ITERATIONS];
  logic signed [XW-1:0]         xs_q [0:ITERATIONS];
  logic signed [XW-1:0]         ys_d [0:ITERATIONS];
  logic signed [XW-1:0]         ys_q [0:ITERATIONS];
  logic signed [ZW-1:0]         zs_d [0:ITERATIONS-1];
  logic signed [ZW-1:0]         zs_q [0:ITERATIONS-1];
  logic signed [XW-1:0]         x_d, x_q, y_d, y_q;
  logic        [CTRL_WIDTH-1:0] ctrl_d [0:LAT-1];
  logic        [CTRL_WIDTH-1:0] ctrl_q [0:LAT-1];

  logic        [1:0]    quad;
  logic signed [N-1:0]  res;
  logic signed [XW-1:0] r_ext;
  logic signed [PW-1:0] prod_x, prod_y;

  always_comb begin
    r_d     = io.r;
    theta_d = io.theta;

    // Rounding theta by half a quadrant keeps the residual angle within +/-45 degrees
    quad  = 2'((theta_q + N'(Q / 2)) >> (N - 2));
    res   = theta_q - {quad, {(N - 2){1'b0}}};
    r_ext = XW'(r_q);
    case (quad)
      2'd0:    begin xs_d[0] = r_ext;  ys_d[0] = '0;     end
      2'd1:    begin xs_d[0] = '0;     ys_d[0] = r_ext;  end
      2'd2:    begin xs_d[0] = -r_ext; ys_d[0] = '0;     end
      default: begin xs_d[0] = '0;     ys_d[0] = -r_ext; end
    endcase
    zs_d[0] = ZW'(res) <<< 8;

    for (int i = 0; i < ITERATIONS; i++) begin
      if (zs_q[i][ZW-1]) begin
        xs_d[i+1] = xs_q[i] + (ys_q[i] >>> i);
        ys_d[i+1] = ys_q[i] - (xs_q[i] >>> i);
      end else begin
        xs_d[i+1] = xs_q[i] - (ys_q[i] >>> i);
        ys_d[i+1] = ys_q[i] + (xs_q[i] >>> i);
      end
    end
    for (int i = 0; i < ITERATIONS - 1; i++) begin
      zs_d[i+1] = zs_q[i][ZW-1] ? zs_q[i] + atan_lut(i) : zs_q[i] - atan_lut(i);
    end

    prod_x = PW'(xs_q[ITERATIONS]) * KINV_S;
    prod_y = PW'(ys_q[ITERATIONS]) * KINV_S;
    if (COMPENSATION_SCALING != 0) begin
      x_d = XW'(prod_x >>> 16);
      y_d = XW'(prod_y >>> 16);
    end else begin
      x_d = xs_q[ITERATIONS];
      y_d = ys_q[ITERATIONS];
    end

    ctrl_d[0] = io.ctrl_in;
    for (int k = 1; k < LAT; k++) begin
      ctrl_d[k] = ctrl_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q     <= '0;
      theta_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      for (int i = 0; i <= ITERATIONS; i++) begin
        xs_q[i] <= '0;
        ys_q[i] <= '0;
      end
      for (int i = 0; i < ITERATIONS; i++) begin
        zs_q[i] <= '0;
      end
      for (int k = 0; k < LAT; k++) begin
        ctrl_q[k] <= '0;
      end
    end else begin
      r_q     <= r_d;
      theta_q <= theta_d;
      x_q     <= x_d;
      y_q     <= y_d;
      xs_q    <= xs_d;
      ys_q    <= ys_d;
      zs_q    <= zs_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign io.x        = x_q;
  assign io.y        = y_q;
  assign io.ctrl_out = ctrl_q[LAT-1];

endmodule
